serial_digit_deserializer: RTL and testbench

//  Parametrised serial-frame receiver: samples 1-bit line serIn, detects start bit, shifts
//  NUM_DIGITS x DIGIT_W data bits, checks stop bit, publishes digits on a packed bus.

---
 rtl/serial_digit_deserializer.sv | 188 ++++++++++++++++++
 tb/tb_serial_digit_deserializer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_digit_deserializer.sv
// Serial frame receiver: start bit, NUM_DIGITS*DIGIT_W data bits, stop bit, digits on a packed bus.
// Optional even-parity bit after the data when PARITY_CHECK_EN is defined.
module serial_digit_deserializer #(
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          ser_i,
  input  logic                          ack_i,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits_o,
  output logic                          valid_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic                          busy_o
);

  localparam int TOTAL = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(TOTAL) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;
`ifdef PARITY_CHECK_EN
  localparam logic [2:0] S_PAR   = 3'd2;
`endif

  // The shift register holds bits in arrival order (bit i = i-th received); reorder per digit on commit.
  function automatic logic [TOTAL-1:0] order_digits(input logic [TOTAL-1:0] raw);
    logic [TOTAL-1:0] res;
    res = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      for (int j = 0; j < DIGIT_W; j++) begin
        if (MSB_FIRST != 0) res[k*DIGIT_W + j] = raw[k*DIGIT_W + DIGIT_W - 1 - j];
        else                res[k*DIGIT_W + j] = raw[k*DIGIT_W + j];
      end
    end
    return res;
  endfunction

`ifdef PARITY_CHECK_EN
  function automatic logic even_parity_ok(input logic [TOTAL-1:0] data, input logic par);
    return ~(^data ^ par);
  endfunction
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOTAL-1:0] shift_q, shift_d;
  logic [TOTAL-1:0] digits_q, digits_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             commit_s, reject_s, stop_ok_s;

`ifdef PARITY_CHECK_EN
  logic             par_ok_q, par_ok_d;
  assign stop_ok_s = par_ok_q;
`else
  assign stop_ok_s = 1'b1;
`endif

  // Frame sequencing: start detect, data shift, optional parity, stop check, break wait.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    commit_s = 1'b0;
    reject_s = 1'b0;
`ifdef PARITY_CHECK_EN
    par_ok_d = par_ok_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!ser_i) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        shift_d            = shift_q >> 1;
        shift_d[TOTAL-1]   = ser_i;
        if (cnt_q == LAST_CNT) begin
`ifdef PARITY_CHECK_EN
          state_d = S_PAR;
`else
          state_d = S_STOP;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef PARITY_CHECK_EN
      S_PAR: begin
        par_ok_d = even_parity_ok(shift_q, ser_i);
        state_d  = S_STOP;
      end
`endif
      S_STOP: begin
        if (ser_i) begin
          state_d  = S_IDLE;
          commit_s = stop_ok_s;
          reject_s = ~stop_ok_s;
        end else begin
          state_d  = S_BREAK;
          reject_s = 1'b1;
        end
      end
      S_BREAK: begin
        if (ser_i) state_d = S_IDLE;
        else       state_d = S_BREAK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output bookkeeping: ack clears first, then a commit or reject on the same edge takes priority.
  always_comb begin
    digits_d    = digits_q;
    valid_d     = valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    busy_d      = (state_d != S_IDLE);
    if (ack_i) begin
      frame_err_d = 1'b0;
      if (valid_q) begin
        valid_d   = 1'b0;
        overrun_d = 1'b0;
      end else begin
        overrun_d = overrun_q;
      end
    end else begin
      frame_err_d = frame_err_q;
    end
    if (commit_s) begin
      digits_d    = order_digits(shift_q);
      valid_d     = 1'b1;
      frame_err_d = 1'b0;
      overrun_d   = valid_q ? ~ack_i : overrun_q;
    end else if (reject_s) begin
      frame_err_d = 1'b1;
    end else begin
      digits_d = digits_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      digits_q    <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_ok_q    <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      digits_q    <= digits_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
`ifdef PARITY_CHECK_EN
      par_ok_q    <= par_ok_d;
`endif
    end
  end

  assign digits_o    = digits_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_serial_digit_deserializer.sv
// Scoreboard bench for serial_digit_deserializer (4 digits x 4 bits, MSB first).
// A frame-level reference model predicts outputs; a monitor checks them whenever busy falls.
module tb_serial_digit_deserializer;

  localparam int W     = 4;
  localparam int N     = 4;
  localparam int MSBF  = 1;
  localparam int TOTAL = W * N;
`ifdef PARITY_CHECK_EN
  localparam int PLEN = 1;
`else
  localparam int PLEN = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ser;
  logic             ack;
  logic [TOTAL-1:0] digits;
  logic             valid, frame_err, overrun, busy;

  serial_digit_deserializer #(.DIGIT_W(W), .NUM_DIGITS(N), .MSB_FIRST(MSBF)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ser_i(ser), .ack_i(ack),
    .digits_o(digits), .valid_o(valid), .frame_err_o(frame_err),
    .overrun_o(overrun), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TOTAL-1:0] digits;
    logic             valid;
    logic             ferr;
    logic             ovr;
    int               len;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state (frame-level view of the outputs).
  logic [TOTAL-1:0] m_digits = '0;
  logic             m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Digit k is built from the k-th group of W received bits (first bit = MSB when MSBF).
  function automatic logic [TOTAL-1:0] model_digits(input logic [TOTAL-1:0] word);
    logic [TOTAL-1:0] r;
    int val, b;
    r = '0;
    for (int k = 0; k < N; k++) begin
      val = 0;
      for (int j = 0; j < W; j++) begin
        b = int'(word[TOTAL-1-(k*W+j)]);
        if (MSBF != 0) val = val * 2 + b;
        else           val = val + (b << j);
      end
      r[k*W +: W] = W'(val);
    end
    return r;
  endfunction

  task automatic model_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    m_ferr = 1'b0;
  endtask

  // word is in arrival order: word[TOTAL-1] is the first data bit on the line.
  task automatic send_frame(input logic [TOTAL-1:0] word, input logic stop, input logic par_flip,
                            input logic ack_at_stop, input int brk);
    exp_t e;
    logic pok, old_v;
    @(posedge clk); #1; ack = 1'b0; ser = 1'b0;
    for (int i = 0; i < TOTAL; i++) begin
      @(posedge clk); #1; ser = word[TOTAL-1-i];
    end
`ifdef PARITY_CHECK_EN
    @(posedge clk); #1; ser = (^word) ^ par_flip;
    pok = ~par_flip;
`else
    pok = 1'b1;
`endif
    @(posedge clk); #1; ser = stop; ack = ack_at_stop;
    old_v = m_valid;
    if (stop && pok) begin
      m_digits = model_digits(word);
      if (old_v) m_ovr = ~ack_at_stop;
      m_valid = 1'b1;
      m_ferr  = 1'b0;
    end else begin
      if (ack_at_stop && old_v) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      m_ferr = 1'b1;
    end
    e.digits = m_digits; e.valid = m_valid; e.ferr = m_ferr; e.ovr = m_ovr;
    e.len    = stop ? TOTAL + 1 + PLEN : TOTAL + 2 + PLEN + brk;
    exp_q.push_back(e);
    if (!stop) begin
      for (int i = 0; i < brk; i++) begin
        @(posedge clk); #1; ack = 1'b0;
      end
      @(posedge clk); #1; ack = 1'b0; ser = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic gap(input int n, input logic do_ack);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ser = 1'b1;
      ack = do_ack && (i == 0);
      if (do_ack && i == 0) model_ack();
    end
  endtask

  // Monitor: on every busy falling edge, compare outputs and busy duration with the next expectation.
  initial begin : monitor
    logic prev_busy;
    int   blen;
    exp_t e;
    prev_busy = 1'b0;
    blen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
        blen = 0;
      end else begin
        if (busy) blen++;
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame_end: got busy fall expected none at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("digits",    32'(digits),    32'(e.digits));
            check("valid",     32'(valid),     32'(e.valid));
            check("frame_err", 32'(frame_err), 32'(e.ferr));
            check("overrun",   32'(overrun),   32'(e.ovr));
            check("busy_len",  32'(blen),      32'(e.len));
          end
          blen = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    rst_n = 1'b0; ser = 1'b1; ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_digits",  32'(digits),    32'h0);
    check("rst_valid",   32'(valid),     32'h0);
    check("rst_busy",    32'(busy),      32'h0);
    check("rst_ferr",    32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun),   32'h0);

    // Reference frame 0110_1100_1010_0111.
    send_frame(16'b0110_1100_1010_0111, 1'b1, 1'b0, 1'b0, 0);
    gap(2, 1'b0);
    check("ref_digits", 32'(digits), 32'h7AC6);
    check("ref_valid",  32'(valid),  32'h1);
    gap(1, 1'b1);
    gap(1, 1'b0);
    check("ack_valid",  32'(valid),  32'h0);

    // Same frame with a bad stop bit, line held low for 3 clocks.
    send_frame(16'b0110_1100_1010_0111, 1'b0, 1'b0, 1'b0, 3);
    gap(2, 1'b0);

    // Two good frames back to back without ack, then ack.
    send_frame(16'h1357, 1'b1, 1'b0, 1'b0, 0);
    send_frame(16'h9BDF, 1'b1, 1'b0, 1'b0, 0);
    gap(2, 1'b1);
    gap(1, 1'b0);
    check("ovr_ack_overrun", 32'(overrun), 32'h0);
    check("ovr_ack_valid",   32'(valid),   32'h0);

    // Reset in the middle of the data bits.
    send_frame(16'h0F0F, 1'b1, 1'b0, 1'b0, 0);
    @(posedge clk); #1; ser = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; ser = 1'(i & 1);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_digits", 32'(digits),    32'h0);
    check("midrst_valid",  32'(valid),     32'h0);
    check("midrst_busy",   32'(busy),      32'h0);
    check("midrst_ferr",   32'(frame_err), 32'h0);
    m_digits = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1; ser = 1'b1;
    gap(2, 1'b0);
    send_frame(16'hA5C3, 1'b1, 1'b0, 1'b0, 0);
    gap(2, 1'b1);

`ifdef PARITY_CHECK_EN
    send_frame(16'h1234, 1'b1, 1'b0, 1'b0, 0);
    gap(2, 1'b1);
    send_frame(16'h1234, 1'b1, 1'b1, 1'b0, 0);
    gap(2, 1'b1);
`endif

    // Randomised frames: good/bad stop, parity errors, ack on the stop edge, idle gaps.
    for (int f = 0; f < 40; f++) begin
      logic [TOTAL-1:0] w;
      logic st, pf, as;
      w  = TOTAL'($urandom);
      st = ($urandom_range(0, 9) != 0);
      pf = (PLEN != 0) && ($urandom_range(0, 4) == 0);
      as = ($urandom_range(0, 3) == 0);
      send_frame(w, st, pf, as, int'($urandom_range(0, 3)));
      gap(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    gap(2, 1'b0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending frames expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
